// File: rtl/i2c_target_if.sv
// Bus bundle for i2c_target: raw I2C pad signals plus the fabric register port.
interface i2c_target_if;
    logic       scl;
    logic       sda;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       reg_re;
    logic       busy;
    logic       nack_seen;

    modport slave (
        input  scl, sda, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, nack_seen
    );
    modport master (
        output scl, sda, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy, nack_seen
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register pointer; open-drain SDA, no clock stretching.
// Optional I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on scl/sda.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h60,
    parameter int         SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    i2c_target_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, READ, READ_ACK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_f, sda_f, scl_q, sda_q;

    // Idle bus level is high, so the synchronizers reset to 1 to avoid a fake START.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda};
        end
    end
    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_s};
            sda_hist <= {sda_hist[0], sda_s};
            scl_f    <= (scl_s & scl_hist[0]) | (scl_s & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
            sda_f    <= (sda_s & sda_hist[0]) | (sda_s & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
        end
    end
`else
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    logic scl_rise, scl_fall, start_c, stop_c;
    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;
    assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shreg, shreg_n, ptr, ptr_n, wdata, wdata_n, rx_byte;
    logic       oe, oe_n, we, we_n, busy, busy_n, nack, nack_n, rd_req;
    logic [2:0] rd_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            ptr     <= '0;
            wdata   <= '0;
            oe      <= 1'b0;
            we      <= 1'b0;
            busy    <= 1'b0;
            nack    <= 1'b0;
            rd_pipe <= '0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            ptr     <= ptr_n;
            wdata   <= wdata_n;
            oe      <= oe_n;
            we      <= we_n;
            busy    <= busy_n;
            nack    <= nack_n;
            rd_pipe <= {rd_pipe[1:0], rd_req};
            scl_q   <= scl_f;
            sda_q   <= sda_f;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        ptr_n   = ptr;
        wdata_n = wdata;
        oe_n    = oe;
        we_n    = 1'b0;
        busy_n  = busy;
        nack_n  = 1'b0;
        rd_req  = 1'b0;
        rx_byte = {shreg[6:0], sda_f};
        if (start_c) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (stop_c) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shreg_n = rx_byte;
                    cnt_n   = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_n = '0;
                        // General call (address 0) never matches.
                        if (rx_byte[7:1] == DEV_ADDR && rx_byte[7:1] != 7'd0) begin
                            state_n = ADDR_ACK;
                            busy_n  = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) oe_n = 1'b1;
                    else if (scl_rise) begin
                        cnt_n = '0;
                        if (shreg[0]) begin
                            state_n = READ;
                            rd_req  = 1'b1;
                        end else begin
                            state_n = SUB;
                        end
                    end
                SUB, WDATA: if (scl_fall) oe_n = 1'b0;
                    else if (scl_rise) begin
                        shreg_n = rx_byte;
                        cnt_n   = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n = '0;
                            if (state == SUB) begin
                                ptr_n   = rx_byte;
                                state_n = SUB_ACK;
                            end else begin
                                wdata_n = rx_byte;
                                we_n    = 1'b1;
                                state_n = WDATA_ACK;
                            end
                        end
                    end
                SUB_ACK: if (scl_fall) oe_n = 1'b1;
                    else if (scl_rise) state_n = WDATA;
                WDATA_ACK: if (scl_fall) begin
                        oe_n  = 1'b1;
                        ptr_n = ptr + 8'd1;
                    end else if (scl_rise) state_n = WDATA;
                // Falls 1..8 present data bits; the 9th fall releases SDA for the master's ACK.
                READ: if (scl_fall) begin
                    if (cnt == 4'd8) begin
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = READ_ACK;
                    end else begin
                        oe_n    = ~shreg[7];
                        shreg_n = {shreg[6:0], 1'b0};
                        cnt_n   = cnt + 4'd1;
                    end
                end
                READ_ACK: if (scl_rise) begin
                    if (!sda_f) begin
                        ptr_n   = ptr + 8'd1;
                        rd_req  = 1'b1;
                        cnt_n   = '0;
                        state_n = READ;
                    end else begin
                        nack_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
        end
        // reg_rdata is guaranteed valid two clocks after reg_re.
        if (rd_pipe[2]) shreg_n = bus.reg_rdata;
    end

    assign bus.sda_oe    = oe;
    assign bus.reg_addr  = ptr;
    assign bus.reg_wdata = wdata;
    assign bus.reg_we    = we;
    assign bus.reg_re    = rd_pipe[0];
    assign bus.busy      = busy;
    assign bus.nack_seen = nack;
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) that answers the team's I2C_Driver master transactions: START, addr+rw, sub_addr, then data write or read.
- Exposes an 8-bit-addressed register port to fabric logic.
- Used to emulate the altimeter/camera register maps in system benches, and to publish telemetry registers to an external master.
- Open-drain SDA drive only; SCL is input-only (no stretching).

Parameters:
- DEV_ADDR, 7'h60, 7-bit target address matched in the address byte.
- SYNC_STAGES, 2, synchronizer flops on scl/sda (valid values 2..4).

Ports:
- clk  in  1  system clock (50 MHz; SCL ≤ 400 kHz).
- rst  in  1  synchronous, active-high reset.
- scl  in  1  bus clock, raw pad input.
- sda  in  1  bus data, raw pad input.
- sda_oe  out  1  1 = pull SDA low; top level builds the open-drain pad (SDA = sda_oe ? 0 : z).
- reg_addr  out  8  current register pointer.
- reg_wdata  out  8  byte received from master.
- reg_we  out  1  one-cycle write strobe.
- reg_rdata  in  8  register contents at reg_addr; fabric returns it combinationally or registered, valid within 2 clk.
- reg_re  out  1  one-cycle strobe when a read byte is loaded for shifting (pointer then advances).
- busy  out  1  high from address match until STOP/repeated START.
- nack_seen  out  1  one-cycle pulse when master NACKs a read byte.

Behaviour:
- Reset values: all outputs 0; pointer = 0; state IDLE. Reset is honoured mid-transfer and releases SDA in the same cycle.
- scl/sda pass through SYNC_STAGES flops. Edge detection runs on the synchronized values: rise/fall of scl.
- START: sda falls while scl high. STOP: sda rises while scl high. Both are detected in any state.
  - START → state ADDR, bit count 0, sda_oe 0.
  - STOP → IDLE, busy 0.
  - Repeated START behaves as START; the pointer is kept.
- Bits are sampled on scl rise, MSB first.
- sda_oe changes only on scl fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If byte[7:1] = DEV_ADDR: → ADDR_ACK, busy 1.
    - Otherwise: → IDLE; no drive until the next START.
  - ADDR_ACK: drive ACK (sda_oe 1) for one SCL period.
    - rw = 0 → SUB.
    - rw = 1 → READ: pulse reg_re and load a shift register from reg_rdata 2 clk later, before the next scl fall.
  - SUB: shift 8 bits into the pointer, then → SUB_ACK (ACK) → WDATA.
  - WDATA: shift 8 bits. On the 8th rise, set reg_wdata and pulse reg_we with reg_addr = pointer. → WDATA_ACK (ACK); the pointer increments on the ACK-slot scl fall.
    - Further bytes repeat WDATA.
  - READ: drive sda_oe = ~shift[7] on each scl fall for 8 bits, then release → READ_ACK.
  - READ_ACK: sample the master bit on scl rise.
    - 0 (ACK): increment pointer, pulse reg_re, load next byte → READ.
    - 1 (NACK): pulse nack_seen → IDLE (wait for STOP/START).
- Pointer is 8-bit and wraps 8'hFF → 8'h00.
- A STOP or START arriving mid-byte aborts the byte: no reg_we, and a partial write is discarded.
- General call (addr 0) is ignored.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- When defined: after the synchronizer, scl and sda each pass a 3-sample majority filter with 1 clk latency. Pulses shorter than 2 clk are rejected.
- When undefined: synchronized values are used directly, and a 1-clk glitch on scl is seen as an edge.

Test Plan:
- Write: START, 0xC0, sub 0x10, data 0xAB, 0xCD, STOP → ACK on all 4 bytes; reg_we at addr 0x10 = 0xAB, then at addr 0x11 = 0xCD; busy falls at STOP.
- Combined read: START, 0xC0, 0x20, rSTART, 0xC1, master ACKs the first byte and NACKs the second → SDA carries reg[0x20]=0x5A then reg[0x21]=0x3C; nack_seen pulses once.
- Address mismatch: 0xA0 → no ACK (sda_oe stays 0 throughout); no reg_we; busy 0.
- Wrap: sub 0xFF, write 0x11, 0x22 → writes land at 0xFF then 0x00.
- Abort: STOP after 4 data bits → no reg_we; the next transaction at 0xC0 is ACKed. Asserting rst mid-READ → sda_oe 0 on the next clk.
- Glitch filter: a 1-clk low pulse on scl with the macro defined → bit count unchanged; without the macro, the count advances.
